// File: rtl/xpush_reader.sv
`default_nettype none
// ============================================================================
// Module   : xpush_reader
// Purpose  : Debounces the 2-bit push-button code (bit0 AC, bit1 C), emits
//            one-cycle command pulses and keeps sticky flags read via sel/rd.
//            Optional macro XPUSH_REPEAT_EN: auto-repeat while a button is held.
// Revision : 1.0 - initial release
// ============================================================================
module xpush_reader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       rd,
  input  logic [1:0] push_code,
  output logic [1:0] data_out,
  output logic       event_valid,
  output logic       ac_pulse,
  output logic       c_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw_q;
  logic [1:0]       stable_q;
  logic [1:0]       stable_d;
  logic [1:0]       stable_dly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       pending_q;
  logic [1:0]       pending_d;
  logic [1:0]       data_q;
  logic [1:0]       data_d;
  logic             ac_q;
  logic             ac_d;
  logic             c_q;
  logic             c_d;
  logic [1:0]       rise;
  logic [1:0]       ev;
  logic             rd_en;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      stable_d[b] = stable_q[b];
      cnt_d[b]    = cnt_q[b];
      if (raw_q[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        stable_d[b] = raw_q[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

`ifdef XPUSH_REPEAT_EN
  // Counter sits at 0 on the press cycle, so the first repeat lands exactly one
  // period later; reloading with 1 keeps subsequent repeats on the same grid.
  localparam logic [15:0] REP_PERIOD = 16'd50000;

  logic [15:0] rep_q [2];
  logic [15:0] rep_d [2];
  logic [1:0]  rep_fire;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      rep_fire[b] = 1'b0;
      rep_d[b]    = rep_q[b];
      if (!stable_q[b]) begin
        rep_d[b] = '0;
      end else if (rep_q[b] == REP_PERIOD) begin
        rep_fire[b] = 1'b1;
        rep_d[b]    = 16'd1;
      end else begin
        rep_d[b] = rep_q[b] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q[0] <= '0;
      rep_q[1] <= '0;
    end else begin
      rep_q[0] <= rep_d[0];
      rep_q[1] <= rep_d[1];
    end
  end

  assign ev = rise | rep_fire;
`else
  assign ev = rise;
`endif

  assign rd_en = sel & rd;

  // New events override a same-cycle read clear; AC wipes any pending C.
  always_comb begin
    pending_d = rd_en ? 2'b00 : pending_q;
    if (ev[1]) pending_d[1] = 1'b1;
    if (ev[0]) pending_d = 2'b01;
    data_d = rd_en ? pending_q : data_q;
    ac_d   = ev[0];
    c_d    = ev[1] & ~ev[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q        <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      pending_q    <= '0;
      data_q       <= '0;
      ac_q         <= 1'b0;
      c_q          <= 1'b0;
    end else begin
      raw_q        <= push_code;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      pending_q    <= pending_d;
      data_q       <= data_d;
      ac_q         <= ac_d;
      c_q          <= c_d;
    end
  end

  assign data_out    = data_q;
  assign event_valid = |pending_q;
  assign ac_pulse    = ac_q;
  assign c_pulse     = c_q;

endmodule
`default_nettype wire
